napot_encoder: RTL and testbench
================================

NAPOT_ENCODER -- requirements
Module: napot_encoder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  region-encode request present.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_base  input  32  region base byte address, unsigned.
REQ-007 req_log2size  input  6  log2 of region size in bytes; legal range 3..31.
REQ-008 rsp_valid  output  1  encoded result available; high only in DONE.
REQ-009 rsp_ready  input  1  consumer accepts the result.
REQ-010 rsp_addr_n  output  32  encoded NAPOT address-register value; 0 on any error.
REQ-011 rsp_err  output  2  00 ok, 01 illegal size, 10 base misaligned, 11 self-check fail.

Function
REQ-012 Encoding SHALL be rsp_addr_n = req_base | ((1<<pos)-1), with pos = req_log2size-3, i.e. pos trailing ones then a zero at bit pos.
REQ-013 FSM states SHALL be IDLE, CHECK, BUILD, VERIFY (macro only), DONE.
REQ-014 IDLE->CHECK on req_valid && req_ready; req_base and req_log2size SHALL be latched that cycle.
REQ-015 CHECK (1 cycle): size outside 3..31 -> err 01; else base bits [log2size-1:0] nonzero -> err 10; either error -> DONE.
REQ-016 CHECK with no error: pos==0 -> DONE (or VERIFY), else -> BUILD with a down-counter loaded with pos.
REQ-017 BUILD: each cycle mask <= (mask<<1)|1 and counter decrements; exits after exactly pos cycles.
REQ-018 For a request accepted in cycle T, rsp_valid SHALL first be high in cycle T+2+pos (error cases: T+2); plus one cycle with the macro defined.
REQ-019 DONE SHALL hold rsp_valid, rsp_addr_n, rsp_err stable until rsp_ready; DONE->IDLE on rsp_ready.
REQ-020 No request SHALL be accepted in the cycle DONE exits; next acceptance earliest the following cycle.
REQ-021 req_valid while req_ready is low SHALL be ignored with no side effect.
REQ-022 Size-range check SHALL precede alignment check when both fail.

Reset
REQ-023 With rst high at a clock edge, state SHALL become IDLE regardless of current state, discarding any in-flight request.
REQ-024 Reset values: req_ready 1, rsp_valid 0, rsp_addr_n 0, rsp_err 00, mask 0, counter 0.

Configuration
REQ-025 Macro NAPOT_ENCODER_SELFCHECK_EN SHALL compile in the VERIFY state.
REQ-026 With the macro: after BUILD (or CHECK when pos==0) go to VERIFY for one cycle; count trailing ones of the encoded value, mismatch with pos or bit pos set -> err 11, rsp_addr_n 0; then DONE.
REQ-027 Without the macro: VERIFY and its logic SHALL be absent; err 11 never produced; latency per REQ-018 without extra cycle.

Structure
REQ-028 Shared package pmp_pkg SHALL hold the FSM state enum, rsp_err code constants, NAPOT_MIN_LOG2 = 3, NAPOT_MAX_LOG2 = 31.
REQ-029 One sub-module, napot_ones_count (combinational trailing-ones counter, 32-bit in, 6-bit out), SHALL be instantiated only under the macro.

Verification
REQ-030 base 0x0000_1000, log2size 12 -> rsp_addr_n 0x0000_11FF, err 00, rsp_valid at T+11 (T+12 with macro).
REQ-031 base 0x2000_0000, log2size 3 -> rsp_addr_n 0x2000_0000, err 00, rsp_valid at T+2.
REQ-032 base 0x0000_1100, log2size 12 -> err 10, rsp_addr_n 0 at T+2; log2size 2 and 32 -> err 01 at T+2.
REQ-033 rsp_ready low 5 cycles in DONE -> outputs stable, req_ready 0; new req_valid accepted one cycle after the rsp handshake.
REQ-034 rst high during BUILD (log2size 20) -> next cycle IDLE, rsp_valid 0, req_ready 1; a subsequent request encodes correctly.
REQ-035 Sweep log2size 3..31 with aligned random bases -> encoding per REQ-012 and latency per REQ-018 for every value.

Source files
------------

// File: rtl/pmp_pkg.sv
// Shared definitions for the NAPOT region encoder: FSM states, response
// error codes and the legal region-size range (log2 bytes).
// The VERIFY state exists only when NAPOT_ENCODER_SELFCHECK_EN is defined.
package pmp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BUILD,
`ifdef NAPOT_ENCODER_SELFCHECK_EN
    S_VERIFY,
`endif
    S_DONE
  } napot_state_t;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_SIZE      = 2'b01;
  localparam logic [1:0] ERR_ALIGN     = 2'b10;
  localparam logic [1:0] ERR_SELFCHECK = 2'b11;

  localparam logic [5:0] NAPOT_MIN_LOG2 = 6'd3;
  localparam logic [5:0] NAPOT_MAX_LOG2 = 6'd31;

endpackage

// File: rtl/napot_ones_count.sv
// Combinational trailing-ones counter: number of consecutive 1 bits
// starting at bit 0. Used only by the optional self-check path
// (NAPOT_ENCODER_SELFCHECK_EN).
module napot_ones_count (
  input  logic [31:0] i_val,
  output logic [5:0]  o_count
);

  logic [5:0] w_cnt;
  logic       w_run;

  // Count ones from the LSB until the first zero.
  always_comb begin
    w_cnt = '0;
    w_run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (w_run && i_val[i]) w_cnt = w_cnt + 6'd1;
      else                   w_run = 1'b0;
    end
  end

  assign o_count = w_cnt;

endmodule

// File: rtl/napot_encoder.sv
// NAPOT address-register encoder: validates a (base, log2size) region and
// builds base | ((1 << (log2size-3)) - 1), one mask bit per BUILD cycle.
// Optional macro NAPOT_ENCODER_SELFCHECK_EN adds a VERIFY state that
// re-counts the trailing ones of the result before responding.
module napot_encoder
  import pmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_base,
  input  logic [5:0]  req_log2size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_addr_n,
  output logic [1:0]  rsp_err
);

  napot_state_t r_state;
  logic [31:0]  r_base;
  logic [5:0]   r_log2;
  logic [31:0]  r_mask;
  logic [4:0]   r_cnt;
  logic         r_req_ready;
  logic         r_rsp_valid;
  logic [31:0]  r_rsp_addr;
  logic [1:0]   r_rsp_err;

  logic         w_size_bad;
  logic [31:0]  w_align_mask;
  logic         w_misaligned;
  logic [5:0]   w_pos;
  logic [31:0]  w_mask_nxt;

  // Size is checked on the full 6-bit value; the alignment mask only
  // matters once the size is known to be in 3..31.
  assign w_size_bad   = (r_log2 < NAPOT_MIN_LOG2) || (r_log2 > NAPOT_MAX_LOG2);
  assign w_align_mask = (32'h1 << r_log2[4:0]) - 32'h1;
  assign w_misaligned = |(r_base & w_align_mask);
  assign w_pos        = r_log2 - NAPOT_MIN_LOG2;
  assign w_mask_nxt   = {r_mask[30:0], 1'b1};

`ifdef NAPOT_ENCODER_SELFCHECK_EN
  logic [31:0] r_enc;
  logic [5:0]  r_pos;
  logic [5:0]  w_ones;

  napot_ones_count u_ones (
    .i_val   (r_enc),
    .o_count (w_ones)
  );
`endif

  // Request/response FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_log2      <= '0;
      r_mask      <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_err   <= ERR_OK;
`ifdef NAPOT_ENCODER_SELFCHECK_EN
      r_enc       <= '0;
      r_pos       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_base      <= req_base;
            r_log2      <= req_log2size;
            r_req_ready <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_mask <= '0;
          // Size error wins over alignment error.
          if (w_size_bad) begin
            r_rsp_err   <= ERR_SIZE;
            r_rsp_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_misaligned) begin
            r_rsp_err   <= ERR_ALIGN;
            r_rsp_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_pos == 6'd0) begin
`ifdef NAPOT_ENCODER_SELFCHECK_EN
            r_enc   <= r_base;
            r_pos   <= w_pos;
            r_state <= S_VERIFY;
`else
            r_rsp_err   <= ERR_OK;
            r_rsp_addr  <= r_base;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
`endif
          end else begin
            r_cnt   <= w_pos[4:0];
`ifdef NAPOT_ENCODER_SELFCHECK_EN
            r_pos   <= w_pos;
`endif
            r_state <= S_BUILD;
          end
        end
        S_BUILD: begin
          r_mask <= w_mask_nxt;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
`ifdef NAPOT_ENCODER_SELFCHECK_EN
            r_enc   <= r_base | w_mask_nxt;
            r_state <= S_VERIFY;
`else
            r_rsp_err   <= ERR_OK;
            r_rsp_addr  <= r_base | w_mask_nxt;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
`endif
          end
        end
`ifdef NAPOT_ENCODER_SELFCHECK_EN
        S_VERIFY: begin
          // Encoded value must have exactly pos trailing ones, then a zero.
          if ((w_ones != r_pos) || r_enc[r_pos[4:0]]) begin
            r_rsp_err  <= ERR_SELFCHECK;
            r_rsp_addr <= '0;
          end else begin
            r_rsp_err  <= ERR_OK;
            r_rsp_addr <= r_enc;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_err   <= ERR_OK;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_addr_n = r_rsp_addr;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_napot_encoder.sv
// Scoreboard bench for napot_encoder: expected responses are queued when a
// request is issued and compared when rsp_valid rises. Honours
// NAPOT_ENCODER_SELFCHECK_EN for the extra latency cycle.
module tb_napot_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_base = '0;
  logic [5:0]  req_log2size = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_addr_n;
  logic [1:0]  rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  err;
    int          lat;
  } rsp_t;

  rsp_t sb[$];

  napot_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_base     (req_base),
    .req_log2size (req_log2size),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_addr_n   (rsp_addr_n),
    .rsp_err      (rsp_err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of one request.
  function automatic rsp_t model(input logic [31:0] b, input int l);
    rsp_t r;
    logic [31:0] m;
    r.addr = '0;
    r.lat  = 2;
    if (l < 3 || l > 31) begin
      r.err = 2'b01;
    end else begin
      m = (32'h1 << l) - 32'h1;
      if ((b & m) != 0) begin
        r.err = 2'b10;
      end else begin
        r.err  = 2'b00;
        r.addr = b | ((32'h1 << (l - 3)) - 32'h1);
        r.lat  = 2 + (l - 3);
`ifdef NAPOT_ENCODER_SELFCHECK_EN
        r.lat  = r.lat + 1;
`endif
      end
    end
    return r;
  endfunction

  // Present a request, wait for acceptance, queue its expectation.
  task automatic drive_req(input logic [31:0] b, input int l, output int t);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_base = b;
    req_log2size = 6'(l);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
    end
    t = cyc;
    sb.push_back(model(b, l));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid and capture what the DUT presents.
  task automatic wait_rsp(input int t, output rsp_t o, output bit to);
    int n = 0;
    while (!rsp_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    to = !rsp_valid;
    o.addr = rsp_addr_n;
    o.err = rsp_err;
    o.lat = cyc - t;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_addr_n !== 32'h0 || rsp_err !== 2'b00) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b addr=%h err=%b, required 1 0 00000000 00",
               req_ready, rsp_valid, rsp_addr_n, rsp_err);
    end
  endtask

  task automatic test_encode();
    logic [31:0] bases[4] = '{32'h0000_1000, 32'h2000_0000, 32'h8000_0000, 32'hFFFF_FF00};
    int          sizes[4] = '{12, 3, 31, 8};
    int t;
    rsp_t o, e;
    bit to;
    for (int i = 0; i < 4; i++) begin
      drive_req(bases[i], sizes[i], t);
      wait_rsp(t, o, to);
      e = sb.pop_front();
      checks++;
      if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
        errors++;
        $display("FAIL encode[%0d]: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
                 i, o.addr, o.err, o.lat, e.addr, e.err, e.lat);
      end
      release_rsp();
    end
  endtask

  task automatic test_errors();
    logic [31:0] bases[6] = '{32'h0000_1100, 32'h0000_1000, 32'h0000_1000, 32'h0, 32'h1, 32'h4};
    int          sizes[6] = '{12, 2, 32, 0, 40, 3};
    int t;
    rsp_t o, e;
    bit to;
    for (int i = 0; i < 6; i++) begin
      drive_req(bases[i], sizes[i], t);
      wait_rsp(t, o, to);
      e = sb.pop_front();
      checks++;
      if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
        errors++;
        $display("FAIL error_case[%0d]: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
                 i, o.addr, o.err, o.lat, e.addr, e.err, e.lat);
      end
      release_rsp();
    end
  endtask

  // Hold the response 5 cycles with a stray request that must be ignored.
  task automatic test_hold();
    int t;
    rsp_t o, e;
    bit to;
    drive_req(32'h0004_0000, 16, t);
    wait_rsp(t, o, to);
    e = sb.pop_front();
    checks++;
    if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
      errors++;
      $display("FAIL hold_rsp: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
               o.addr, o.err, o.lat, e.addr, e.err, e.lat);
    end
    req_valid = 1'b1;
    req_base = 32'h1234_0000;
    req_log2size = 6'd12;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_addr_n !== e.addr || rsp_err !== e.err || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: vld=%b addr=%h err=%b rdy=%b, required 1 %h %b 0",
                 i, rsp_valid, rsp_addr_n, rsp_err, req_ready, e.addr, e.err);
      end
    end
    req_valid = 1'b0;
    release_rsp();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_req: vld=%b rdy=%b, required 0 1", rsp_valid, req_ready);
    end
  endtask

  // New request held high across the response handshake.
  task automatic test_back_to_back();
    int t;
    rsp_t o, e;
    bit to;
    drive_req(32'h0000_0040, 6, t);
    wait_rsp(t, o, to);
    e = sb.pop_front();
    checks++;
    if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
      errors++;
      $display("FAIL b2b_first: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
               o.addr, o.err, o.lat, e.addr, e.err, e.lat);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_base = 32'h0001_0000;
    req_log2size = 6'd10;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exit: rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
    end
    t = cyc;
    sb.push_back(model(32'h0001_0000, 10));
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: rdy=%b, required 0", req_ready);
    end
    wait_rsp(t, o, to);
    e = sb.pop_front();
    checks++;
    if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
      errors++;
      $display("FAIL b2b_second: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
               o.addr, o.err, o.lat, e.addr, e.err, e.lat);
    end
    release_rsp();
  endtask

  // Reset in the middle of BUILD, then a clean request.
  task automatic test_reset_build();
    int t;
    rsp_t o, e;
    bit to;
    drive_req(32'h0010_0000, 20, t);
    repeat (4) @(negedge clk);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_build: rdy=%b vld=%b, required 1 0", req_ready, rsp_valid);
    end
    drive_req(32'h0300_0000, 24, t);
    wait_rsp(t, o, to);
    e = sb.pop_front();
    checks++;
    if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
      errors++;
      $display("FAIL after_reset: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
               o.addr, o.err, o.lat, e.addr, e.err, e.lat);
    end
    release_rsp();
  endtask

  task automatic test_sweep();
    int t;
    rsp_t o, e;
    bit to;
    logic [31:0] b;
    for (int l = 3; l <= 31; l++) begin
      b = $urandom() & ~((32'h1 << l) - 32'h1);
      drive_req(b, l, t);
      wait_rsp(t, o, to);
      e = sb.pop_front();
      checks++;
      if (to || o.addr !== e.addr || o.err !== e.err || o.lat !== e.lat) begin
        errors++;
        $display("FAIL sweep[l=%0d]: addr=%h err=%b lat=%0d, required addr=%h err=%b lat=%0d",
                 l, o.addr, o.err, o.lat, e.addr, e.err, e.lat);
      end
      release_rsp();
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_build();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
